reg_writeback_unit: RTL

// - Write side of the 32x32 register file: takes retired results from execute and load data from memory.
// - Drives the file's write port (write_en/write_addr/write_value) with one registered write per instruction.
// - Sits between the execute/memory stages and the register file.
// - Stalls the upstream stage while a load is outstanding.

---
 rtl/reg_writeback_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/reg_writeback_unit.sv
// Register-file write side: retires ALU/PC+4 results directly and stalls for load data.
// Optional `WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter port.
module reg_writeback_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [1:0]  wb_sel,
  input  logic        rf_wen,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] alu_out,
  input  logic [31:0] pc,
  input  logic [2:0]  funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_value,
  output logic        busy,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0] retire_cnt,
`endif
  output logic        mem_err
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [7:0] TimeoutCycles = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [4:0]  ldRd_q, ldRd_d;
  logic [2:0]  ldF3_q, ldF3_d;
  logic [1:0]  ldOff_q, ldOff_d;
  logic        ldWen_q, ldWen_d;
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wval_q, wval_d;
  logic        err_q, err_d;
  logic        retire;

  // Extract and extend the addressed byte/halfword from the aligned word.
  function automatic logic [31:0] fmtLoad(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = data;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ldRd_d  = ldRd_q;
    ldF3_d  = ldF3_q;
    ldOff_d = ldOff_q;
    ldWen_d = ldWen_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    err_d   = err_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          if (wb_sel == 2'b10) begin
            ldRd_d  = rd_addr;
            ldF3_d  = funct3;
            ldOff_d = alu_out[1:0];
            ldWen_d = rf_wen;
            count_d = 8'd0;
            state_d = WAIT_MEM;
          end else begin
            retire = 1'b1;
            if (wb_sel != 2'b00 && rf_wen && rd_addr != 5'd0) begin
              wen_d   = 1'b1;
              waddr_d = rd_addr;
              wval_d  = (wb_sel == 2'b01) ? alu_out : pc + 32'd4;
            end
          end
        end
      end
      WAIT_MEM: begin
        // Data arriving on the final allowed cycle still beats the timeout.
        if (mem_rvalid) begin
          retire  = 1'b1;
          state_d = IDLE;
          if (ldWen_q && ldRd_q != 5'd0) begin
            wen_d   = 1'b1;
            waddr_d = ldRd_q;
            wval_d  = fmtLoad(ldF3_q, ldOff_q, mem_rdata);
          end
        end else if (count_q + 8'd1 == TimeoutCycles) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      ldRd_q  <= 5'd0;
      ldF3_q  <= 3'd0;
      ldOff_q <= 2'd0;
      ldWen_q <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wval_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ldRd_q  <= ldRd_d;
      ldF3_q  <= ldF3_d;
      ldOff_q <= ldOff_d;
      ldWen_q <= ldWen_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wval_q  <= wval_d;
      err_q   <= err_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retireCnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retireCnt_q <= 64'd0;
    end else if (retire) begin
      retireCnt_q <= retireCnt_q + 64'd1;
    end
  end

  assign retire_cnt = retireCnt_q;
`else
  logic unusedRetire;
  assign unusedRetire = retire;
`endif

  assign wb_ready    = (state_q == IDLE);
  assign busy        = (state_q == WAIT_MEM);
  assign write_en    = wen_q;
  assign write_addr  = waddr_q;
  assign write_value = wval_q;
  assign mem_err     = err_q;

endmodule
